// File: rtl/ad7946_decimator.sv
// -----------------------------------------------------------------------------
// ad7946_decimator
//
// Box-car decimator for a two-channel AD7946 front end. Each channel sums
// 2^LOG2_AVG conversions and emits one averaged 14-bit result, tagged with its
// channel, into a small output FIFO that drains over a valid/ready stream.
//
// Parameters
//   LOG2_AVG    log2 of samples per result, 0..8 (0 = pass-through)
//   FIFO_DEPTH  output FIFO entries, power of two, >= 2
//
// Ports
//   clk        single clock, all state in this domain
//   reset_n    asynchronous active-low reset
//   enable     1 = accumulate, 0 = flush accumulators/counters/pending
//   ch0_dv     one-cycle strobe, din is a channel-0 conversion
//   ch1_dv     one-cycle strobe, din is a channel-1 conversion
//   din        14-bit unsigned conversion result
//   m_valid    output stream valid
//   m_ready    output stream ready
//   m_chan     channel tag of m_data
//   m_data     averaged result
//   ovf        sticky flag, a result was dropped
//   clr_ovf    synchronous clear of ovf (a coincident drop wins)
//
// Build option
//   AD7946_DECIM_ROUND_EN  defined: round half up; undefined: truncate.
//
// Result path: a completing window is registered into a one-entry write stage
// on the edge that samples its final strobe, and enters the FIFO on the next
// edge; m_valid is the FIFO non-empty flag, so it rises two edges after the
// final strobe. When two results compete for the write stage (both channels
// completing together), the older/ch0 one goes first and the other waits one
// cycle in a pending register. A third competitor (only possible at
// LOG2_AVG=0 with back-to-back dual strobes) is dropped and flagged in ovf.
// -----------------------------------------------------------------------------
module ad7946_decimator #(
   parameter int LOG2_AVG   = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable,
   input  logic        ch0_dv,
   input  logic        ch1_dv,
   input  logic [13:0] din,
   output logic        m_valid,
   input  logic        m_ready,
   output logic        m_chan,
   output logic [13:0] m_data,
   output logic        ovf,
   input  logic        clr_ovf
);

   localparam int SW = 14 + LOG2_AVG;                 // accumulator width
   localparam int CW = (LOG2_AVG > 0) ? LOG2_AVG : 1; // counter width
   localparam int AW = $clog2(FIFO_DEPTH);
   // With LOG2_AVG=0 this is 0, so every strobe completes a window.
   localparam logic [CW-1:0] CNT_LAST = CW'((1 << LOG2_AVG) - 1);
`ifdef AD7946_DECIM_ROUND_EN
   localparam logic [SW-1:0] HALF = SW'((1 << LOG2_AVG) >> 1);
`endif

   typedef struct packed {
      logic        valid;
      logic        chan;
      logic [13:0] data;
   } beat_t;

   // Per-channel accumulation
   logic [SW-1:0] acc [2];
   logic [CW-1:0] cnt [2];
   logic [SW-1:0] sum [2];
   logic [13:0]   res [2];
   logic [1:0]    dv;
   logic [1:0]    hit;
   logic [1:0]    last;

   // Write-stage arbitration
   beat_t cand [3];
   beat_t wr_q, wr_d;
   beat_t pend_q, pend_d;
   logic  drop_arb;

   // FIFO
   logic [AW:0] wr_ptr, rd_ptr;
   logic [14:0] mem [FIFO_DEPTH];
   logic        empty, full, pop, push, drop_fifo;

   assign dv = {ch1_dv, ch0_dv};

   // NOTE: combinational blocks assign every output a default first, so no
   // path through them can leave a value held (which would infer a latch).
   always_comb begin
      for (int c = 0; c < 2; c++) begin
         hit[c]  = enable & dv[c];
         last[c] = hit[c] && (cnt[c] == CNT_LAST);
         // Cannot overflow: at most (2^LOG2_AVG) * 0x3FFF, and the rounded
         // form still shifts back to <= 0x3FFF.
         sum[c]  = acc[c] + SW'(din);
`ifdef AD7946_DECIM_ROUND_EN
         res[c]  = 14'((sum[c] + HALF) >> LOG2_AVG);
`else
         res[c]  = 14'(sum[c] >> LOG2_AVG);
`endif
      end
   end

   // Candidates in age/priority order: pending (older), new ch0, new ch1.
   // First free slot is the write stage, second is pending, else drop.
   always_comb begin
      cand[0]  = '{valid: pend_q.valid & enable, chan: pend_q.chan, data: pend_q.data};
      cand[1]  = '{valid: last[0], chan: 1'b0, data: res[0]};
      cand[2]  = '{valid: last[1], chan: 1'b1, data: res[1]};
      wr_d     = '0;
      pend_d   = '0;
      drop_arb = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (cand[i].valid) begin
            if (!wr_d.valid) begin
               wr_d = cand[i];
            end else if (!pend_d.valid) begin
               pend_d = cand[i];
            end else begin
               drop_arb = 1'b1;
            end
         end
      end
   end

   // FIFO status; a pop frees the slot a same-edge push lands in.
   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign pop       = m_valid & m_ready;
   assign push      = wr_q.valid & (~full | pop);
   assign drop_fifo = wr_q.valid & full & ~pop;

   // Outputs are forced to zero when empty so nothing uninitialised from the
   // storage array is ever visible, including during reset.
   assign m_valid          = ~empty;
   assign {m_chan, m_data} = m_valid ? mem[rd_ptr[AW-1:0]] : 15'd0;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of every other flop, independent of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int c = 0; c < 2; c++) begin
            acc[c] <= '0;
            cnt[c] <= '0;
         end
         wr_q   <= '0;
         pend_q <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         ovf    <= 1'b0;
      end else begin
         for (int c = 0; c < 2; c++) begin
            if (!enable || last[c]) begin
               acc[c] <= '0;
               cnt[c] <= '0;
            end else if (hit[c]) begin
               acc[c] <= sum[c];
               cnt[c] <= cnt[c] + CW'(1);
            end
         end
         wr_q   <= wr_d;
         pend_q <= pend_d;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (drop_arb || drop_fifo) begin
            ovf <= 1'b1;
         end else if (clr_ovf) begin
            ovf <= 1'b0;
         end
      end
   end

   // NOTE: the storage array has no reset; validity is carried entirely by
   // the pointers, and leaving it unreset lets it map onto plain RAM/flops.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= {wr_q.chan, wr_q.data};
   end

endmodule

// File: tb/tb_ad7946_decimator.sv
// -----------------------------------------------------------------------------
// tb_ad7946_decimator
//
// Directed bench for ad7946_decimator. Main instance uses LOG2_AVG=2 and
// FIFO_DEPTH=4; a second instance with LOG2_AVG=0 covers pass-through.
// Inputs are driven just after the falling edge and outputs are sampled on the
// falling edge, half a cycle away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_ad7946_decimator;

   logic        clk = 1'b0;
   logic        reset_n, enable, ch0_dv, ch1_dv, m_ready, clr_ovf;
   logic [13:0] din;
   logic        m_valid, m_chan, ovf;
   logic [13:0] m_data;

   logic        z_ch0_dv, z_ch1_dv, z_m_ready;
   logic        z_m_valid, z_m_chan, z_ovf;
   logic [13:0] z_m_data;

   int total = 0;
   int bad   = 0;

`ifdef AD7946_DECIM_ROUND_EN
   localparam logic [13:0] EXP_AVG = 14'd102; // 406/4 = 101.5 rounds up
`else
   localparam logic [13:0] EXP_AVG = 14'd101; // 406/4 = 101.5 truncates
`endif

   always #5 clk = ~clk;

   ad7946_decimator #(.LOG2_AVG(2), .FIFO_DEPTH(4)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .enable  (enable),
      .ch0_dv  (ch0_dv),
      .ch1_dv  (ch1_dv),
      .din     (din),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_chan  (m_chan),
      .m_data  (m_data),
      .ovf     (ovf),
      .clr_ovf (clr_ovf)
   );

   ad7946_decimator #(.LOG2_AVG(0), .FIFO_DEPTH(4)) dut_pass (
      .clk     (clk),
      .reset_n (reset_n),
      .enable  (enable),
      .ch0_dv  (z_ch0_dv),
      .ch1_dv  (z_ch1_dv),
      .din     (din),
      .m_valid (z_m_valid),
      .m_ready (z_m_ready),
      .m_chan  (z_m_chan),
      .m_data  (z_m_data),
      .ovf     (z_ovf),
      .clr_ovf (clr_ovf)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic beat(input string tag, input logic chan, input logic [13:0] data);
      check({tag, "_valid"}, m_valid, 1);
      check({tag, "_chan"},  m_chan,  chan);
      check({tag, "_data"},  m_data,  data);
   endtask

   // One strobe cycle; returns on the falling edge after the sampling edge.
   task automatic strobe(input logic c0, input logic c1, input logic [13:0] d);
      ch0_dv = c0;
      ch1_dv = c1;
      din    = d;
      @(negedge clk);
      ch0_dv = 1'b0;
      ch1_dv = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n   = 1'b0;
      enable    = 1'b1;
      ch0_dv    = 1'b0;
      ch1_dv    = 1'b0;
      din       = '0;
      m_ready   = 1'b1;
      clr_ovf   = 1'b0;
      z_ch0_dv  = 1'b0;
      z_ch1_dv  = 1'b0;
      z_m_ready = 1'b1;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_valid", m_valid, 0);
      check("rst_chan",  m_chan,  0);
      check("rst_data",  m_data,  0);
      check("rst_ovf",   ovf,     0);
      check("rst_pass_valid", z_m_valid, 0);
      reset_n = 1'b1;
      @(negedge clk);

      // Single ch0 window, two-cycle latency
      strobe(1, 0, 14'd100);
      strobe(1, 0, 14'd101);
      strobe(1, 0, 14'd102);
      strobe(1, 0, 14'd103);
      check("avg_lat1_valid", m_valid, 0);
      @(negedge clk);
      beat("avg", 0, EXP_AVG);
      @(negedge clk);
      check("avg_drained", m_valid, 0);

      // Both channels complete together: ch0 then ch1
      repeat (4) strobe(1, 1, 14'd8);
      @(negedge clk);
      beat("dual_ch0", 0, 14'd8);
      @(negedge clk);
      beat("dual_ch1", 1, 14'd8);
      @(negedge clk);
      check("dual_drained", m_valid, 0);

      // Overflow: five full-scale windows into a 4-entry FIFO, no ready
      m_ready = 1'b0;
      repeat (20) strobe(1, 0, 14'h3FFF);
      repeat (2) @(negedge clk);
      check("full_ovf", ovf, 1);
      beat("full_head", 0, 14'h3FFF);
      @(negedge clk);
      beat("full_hold", 0, 14'h3FFF);
      clr_ovf = 1'b1;
      @(negedge clk);
      clr_ovf = 1'b0;
      check("clr_ovf", ovf, 0);

      // Pop and push on the same edge while full: both succeed, no ovf
      repeat (4) strobe(0, 1, 14'd7);
      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;
      check("popush_ovf", ovf, 0);
      m_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         beat($sformatf("drain%0d", i), 0, 14'h3FFF);
         @(negedge clk);
      end
      beat("drain_last", 1, 14'd7);
      @(negedge clk);
      check("drain_empty", m_valid, 0);

      // enable low flushes a partial window and ignores strobes
      strobe(0, 1, 14'd50);
      strobe(0, 1, 14'd50);
      enable = 1'b0;
      strobe(0, 1, 14'd50);
      enable = 1'b1;
      strobe(0, 1, 14'd20);
      strobe(0, 1, 14'd20);
      strobe(0, 1, 14'd20);
      check("flush_no_partial", m_valid, 0);
      strobe(0, 1, 14'd20);
      check("flush_lat1", m_valid, 0);
      @(negedge clk);
      beat("flush", 1, 14'd20);
      @(negedge clk);
      check("flush_single", m_valid, 0);

      // A drop coinciding with clr_ovf leaves ovf set
      m_ready = 1'b0;
      repeat (16) strobe(1, 0, 14'd1);
      repeat (4) strobe(1, 0, 14'd1);
      clr_ovf = 1'b1;
      @(negedge clk);
      clr_ovf = 1'b0;
      check("set_wins", ovf, 1);
      beat("set_wins_head", 0, 14'd1);

      // Reset mid-window with m_valid high
      strobe(1, 0, 14'd1000);
      strobe(1, 0, 14'd1000);
      #2 reset_n = 1'b0;
      #1;
      check("arst_valid", m_valid, 0);
      check("arst_data",  m_data,  0);
      check("arst_ovf",   ovf,     0);
      @(negedge clk);
      reset_n = 1'b1;
      m_ready = 1'b1;
      repeat (3) strobe(1, 0, 14'd500);
      check("arst_fresh3", m_valid, 0);
      @(negedge clk);
      check("arst_fresh3b", m_valid, 0);
      strobe(1, 0, 14'd500);
      @(negedge clk);
      beat("arst_result", 0, 14'd500);
      @(negedge clk);
      check("arst_drained", m_valid, 0);

      // LOG2_AVG=0 pass-through
      z_ch1_dv = 1'b1;
      din      = 14'h1234;
      @(negedge clk);
      z_ch1_dv = 1'b0;
      check("pass_lat1", z_m_valid, 0);
      @(negedge clk);
      check("pass_valid", z_m_valid, 1);
      check("pass_chan",  z_m_chan,  1);
      check("pass_data",  z_m_data,  14'h1234);
      check("pass_ovf",   z_ovf,     0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ad7946_decimator.md
AD7946_DECIMATOR -- requirements
Module: ad7946_decimator

Interface
REQ-001 Parameter LOG2_AVG, default 4, log2 of samples averaged per output; legal range 0..8.
REQ-002 Parameter FIFO_DEPTH, default 4, output FIFO entries; power of two, at least 2.
REQ-003 clk  input  1  single clock; all state in this domain.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  high = accumulate; low = flush accumulators and counters.
REQ-006 ch0_dv  input  1  one-cycle strobe: din holds a channel-0 conversion.
REQ-007 ch1_dv  input  1  one-cycle strobe: din holds a channel-1 conversion.
REQ-008 din  input  14  conversion result, unsigned straight binary.
REQ-009 m_valid  output  1  output stream valid.
REQ-010 m_ready  input  1  output stream ready.
REQ-011 m_chan  output  1  channel tag of m_data (0 or 1).
REQ-012 m_data  output  14  averaged result, unsigned.
REQ-013 ovf  output  1  sticky flag: a result was dropped.
REQ-014 clr_ovf  input  1  synchronous clear of ovf.

Function
REQ-015 The block SHALL keep a (14+LOG2_AVG)-bit accumulator and a LOG2_AVG-bit sample counter per channel.
REQ-016 On a dv strobe with enable high, the block SHALL add din to that channel's accumulator and increment its counter.
REQ-017 On the 2^LOG2_AVG-th sample, the block SHALL form result = (accumulator + din) >> LOG2_AVG, clear the accumulator, wrap the counter to 0 and push {chan, result} to the FIFO.
REQ-018 With LOG2_AVG=0, every sample SHALL pass through unchanged as a result.
REQ-019 A push SHALL enter the FIFO on the clock edge after the final dv cycle; m_valid SHALL rise on the following edge when the FIFO was empty (2-cycle latency from final dv to m_valid).
REQ-020 A transfer SHALL occur on any edge where m_valid and m_ready are both high; m_chan and m_data SHALL stay stable while m_valid is high and m_ready is low.
REQ-021 Results SHALL leave the FIFO in push order.
REQ-022 ch0_dv and ch1_dv high in the same cycle SHALL both be accumulated.
REQ-023 If both channels complete in the same cycle, the ch0 result SHALL be pushed first; the ch1 result SHALL be held in a one-entry pending register and pushed on the next cycle.
REQ-024 A push to a full FIFO SHALL be discarded and SHALL set ovf; a pop and a push on the same edge while full SHALL both succeed.
REQ-025 A pending ch1 result that meets a full FIFO SHALL be discarded and SHALL set ovf.
REQ-026 ovf SHALL stay set until clr_ovf is high; if a set event and clr_ovf coincide, the set SHALL win.
REQ-027 enable low SHALL zero both accumulators, both counters and the pending register, and SHALL ignore dv strobes; FIFO contents SHALL be kept and SHALL drain normally.
REQ-028 Partial averages SHALL never be emitted.

Reset
REQ-029 reset_n low SHALL asynchronously clear accumulators, counters, pending register, FIFO pointers and ovf.
REQ-030 During reset, m_valid, m_chan, m_data and ovf SHALL be 0.
REQ-031 A reset during an averaging window SHALL discard the partial sum; the first result after reset SHALL use 2^LOG2_AVG fresh samples.

Configuration
REQ-032 Macro AD7946_DECIM_ROUND_EN defined: result SHALL be (sum + 2^(LOG2_AVG-1)) >> LOG2_AVG when LOG2_AVG > 0, i.e. round half up.
REQ-033 Macro AD7946_DECIM_ROUND_EN undefined: result SHALL be sum >> LOG2_AVG, i.e. truncation.
REQ-034 Rounding SHALL never exceed 0x3FFF and needs no saturation logic.

Verification (LOG2_AVG=2, FIFO_DEPTH=4 unless noted)
REQ-035 ch0 samples 100,101,102,103, m_ready=1 -> single beat chan=0, data=101 (truncate) or 102 (round), m_valid high 2 cycles after 4th dv.
REQ-036 ch0 and ch1 strobed together 4 times (ch0 with din=8, ch1 with din=8) -> beat chan=0 data=8, then next cycle beat chan=1 data=8.
REQ-037 m_ready=0, five ch0 windows of all 0x3FFF -> four beats of 0x3FFF queued, ovf=1; clr_ovf pulse -> ovf=0.
REQ-038 Two ch1 samples of 50, then enable=0 for 1 cycle, then four samples of 20 -> only one beat, chan=1 data=20.
REQ-039 reset_n pulsed low mid-window with m_valid high -> m_valid=0 immediately; next output needs four new samples.
REQ-040 LOG2_AVG=0: ch1 din=0x1234 -> beat chan=1 data=0x1234 after 2 cycles.
